// File: rtl/mfb_frame_gen.sv
// mfb_frame_gen: MFB test-frame generator.
// On an accepted START it sends FRAME_COUNT frames of FRAME_LEN items each.
// Every frame begins at region 0 / block 0 of a fresh word. Item k of frame f
// carries (f + k) mod 2^MFB_ITEM_WIDTH, and items past EOF are zero.
// Ports:
//   CLK, RESET              clock, synchronous active-high reset
//   START                   one-cycle run request (honoured only when idle)
//   FRAME_COUNT, FRAME_LEN  run parameters, captured on the accepted START
//   BUSY, DONE              run in progress / one-cycle end-of-run pulse
//   TX_*                    MFB source interface (DATA, SOF, EOF, SOF_POS,
//                           EOF_POS, SRC_RDY out; DST_RDY in)
module mfb_frame_gen #(
  parameter int unsigned MFB_REGIONS    = 4,
  parameter int unsigned MFB_REG_SIZE   = 8,
  parameter int unsigned MFB_BLOCK_SIZE = 8,
  parameter int unsigned MFB_ITEM_WIDTH = 8,
  localparam int unsigned RI  = MFB_REG_SIZE * MFB_BLOCK_SIZE,
  localparam int unsigned WI  = MFB_REGIONS * RI,
  localparam int unsigned DW  = WI * MFB_ITEM_WIDTH,
  localparam int unsigned SBW = (MFB_REG_SIZE > 1) ? $clog2(MFB_REG_SIZE) : 1,
  localparam int unsigned EBW = (RI > 1) ? $clog2(RI) : 1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       START,
  input  logic [31:0]                FRAME_COUNT,
  input  logic [15:0]                FRAME_LEN,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [DW-1:0]              TX_DATA,
  output logic [MFB_REGIONS-1:0]     TX_SOF,
  output logic [MFB_REGIONS-1:0]     TX_EOF,
  output logic [MFB_REGIONS*SBW-1:0] TX_SOF_POS,
  output logic [MFB_REGIONS*EBW-1:0] TX_EOF_POS,
  output logic                       TX_SRC_RDY,
  input  logic                       TX_DST_RDY
);

  localparam int unsigned IW = MFB_ITEM_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;        // frames in this run
  logic [31:0] frame_q, frame_d;    // frame currently presented
  logic [15:0] len_q, len_d;        // items per frame
  logic [15:0] last_q, last_d;      // index of the last word of a frame
  logic [15:0] word_q, word_d;      // word index within the current frame
  logic        load;                // capture the next word into the output regs

  logic                   src_rdy_d, busy_d, done_d;
  logic [DW-1:0]          gen_data;
  logic [MFB_REGIONS-1:0] gen_sof, gen_eof;
  logic [MFB_REGIONS*EBW-1:0] gen_eof_pos;
  logic [31:0]            gen_lenm1, gen_base, gen_eof_reg;

  // Next-state, counter and load control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    len_d   = len_q;
    last_d  = last_q;
    word_d  = word_q;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          cnt_d   = FRAME_COUNT;
          len_d   = FRAME_LEN;
          last_d  = 16'((32'(FRAME_LEN) - 32'd1) / 32'(WI));
          frame_d = 32'd0;
          word_d  = 16'd0;
          if (FRAME_COUNT == 32'd0 || FRAME_LEN == 16'd0) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_SEND;
            load    = 1'b1;
          end
        end
      end
      ST_SEND: begin
        // TX_SRC_RDY is high for the whole of SEND, so DST_RDY alone means transfer
        if (TX_DST_RDY) begin
          if (word_q == last_q) begin
            if (frame_q == cnt_q - 32'd1) begin
              state_d = ST_FINISH;
            end else begin
              frame_d = frame_q + 32'd1;
              word_d  = 16'd0;
              load    = 1'b1;
            end
          end else begin
            word_d = word_q + 16'd1;
            load   = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    src_rdy_d = (state_d == ST_SEND);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_FINISH);
  end

  // Contents of the word addressed by the next-cycle counters
  always_comb begin
    gen_data    = '0;
    gen_sof     = '0;
    gen_eof     = '0;
    gen_eof_pos = '0;
    gen_lenm1   = 32'(len_d) - 32'd1;
    gen_base    = 32'(word_d) * 32'(WI);
    gen_eof_reg = (gen_lenm1 / 32'(RI)) % 32'(MFB_REGIONS);

    for (int unsigned i = 0; i < WI; i++) begin
      if ((gen_base + 32'(i)) < 32'(len_d)) begin
        gen_data[i*IW +: IW] = IW'(frame_d + gen_base + 32'(i));
      end
    end

    gen_sof[0] = (word_d == 16'd0);

    if (word_d == last_d) begin
      for (int unsigned r = 0; r < MFB_REGIONS; r++) begin
        if (32'(r) == gen_eof_reg) begin
          gen_eof[r]                  = 1'b1;
          gen_eof_pos[r*EBW +: EBW]   = EBW'(gen_lenm1 % 32'(RI));
        end
      end
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      frame_q    <= '0;
      len_q      <= '0;
      last_q     <= '0;
      word_q     <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      TX_SRC_RDY <= 1'b0;
      TX_DATA    <= '0;
      TX_SOF     <= '0;
      TX_EOF     <= '0;
      TX_SOF_POS <= '0;
      TX_EOF_POS <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      len_q      <= len_d;
      last_q     <= last_d;
      word_q     <= word_d;
      BUSY       <= busy_d;
      DONE       <= done_d;
      TX_SRC_RDY <= src_rdy_d;
      // Frames always start at block 0, so SOF_POS stays zero
      TX_SOF_POS <= '0;
      if (load) begin
        TX_DATA    <= gen_data;
        TX_SOF     <= gen_sof;
        TX_EOF     <= gen_eof;
        TX_EOF_POS <= gen_eof_pos;
      end
    end
  end

endmodule

// File: tb/tb_mfb_frame_gen.sv
// tb_mfb_frame_gen: directed bench for mfb_frame_gen with default parameters
// (4 regions x 8 blocks x 8 items x 8 bits -> 256 items per 2048-bit word).
module tb_mfb_frame_gen;

  localparam int R  = 4;
  localparam int IW = 8;
  localparam int WI = 256;
  localparam int DW = 2048;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          START;
  logic [31:0]   FRAME_COUNT;
  logic [15:0]   FRAME_LEN;
  logic          BUSY, DONE;
  logic [DW-1:0] TX_DATA;
  logic [R-1:0]  TX_SOF, TX_EOF;
  logic [11:0]   TX_SOF_POS;
  logic [23:0]   TX_EOF_POS;
  logic          TX_SRC_RDY;
  logic          TX_DST_RDY;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sig_a, sig_b;

  always #5 CLK = ~CLK;

  mfb_frame_gen dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .FRAME_COUNT(FRAME_COUNT),
    .FRAME_LEN  (FRAME_LEN),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .TX_DATA    (TX_DATA),
    .TX_SOF     (TX_SOF),
    .TX_EOF     (TX_EOF),
    .TX_SOF_POS (TX_SOF_POS),
    .TX_EOF_POS (TX_EOF_POS),
    .TX_SRC_RDY (TX_SRC_RDY),
    .TX_DST_RDY (TX_DST_RDY)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected word: item k of frame f is (f+k) mod 256, zero past the frame end
  function automatic logic [DW-1:0] exp_data(input int f, input int w, input int len);
    logic [DW-1:0] d;
    int k;
    d = '0;
    for (int i = 0; i < WI; i++) begin
      k = w * WI + i;
      if (k < len) d[i*IW +: IW] = IW'(f + k);
    end
    return d;
  endfunction

  function automatic logic [31:0] fold(input logic [DW-1:0] d);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < DW / 32; i++) s ^= d[i*32 +: 32];
    return s;
  endfunction

  task automatic check_data(input string tag, input int f, input int w, input int len);
    logic [DW-1:0] e;
    int bad;
    e = exp_data(f, w, len);
    n_cmp++;
    assert (TX_DATA === e) else begin
      bad = 0;
      for (int i = WI - 1; i >= 0; i--) if (TX_DATA[i*IW +: IW] !== e[i*IW +: IW]) bad = i;
      n_err++;
      $error("FAIL %s frame %0d word %0d item %0d: observed %0h expected %0h",
             tag, f, w, bad, TX_DATA[bad*IW +: IW], e[bad*IW +: IW]);
    end
  endtask

  // One complete run; eof_mask/eof_pos are the hand-computed last-word EOF fields
  task automatic run_stream(input int len, input int cnt, input bit stall, input bit poke,
                            input logic [3:0] eof_mask, input logic [23:0] eof_pos,
                            input int exp_xfers, output logic [31:0] sig);
    int f, w, wpf, nx, iter, last_x, done_iter;
    bit stalled, done_seen, rdy;
    logic [DW-1:0] h_data;
    logic [3:0]    h_sof, h_eof;
    logic [11:0]   h_sp;
    logic [23:0]   h_ep;
    f = 0; w = 0; nx = 0; iter = 0; last_x = -10; done_iter = 0;
    stalled = 0; done_seen = 0; sig = '0;
    h_data = '0; h_sof = '0; h_eof = '0; h_sp = '0; h_ep = '0;
    wpf = (len + WI - 1) / WI;
    FRAME_LEN   = 16'(len);
    FRAME_COUNT = 32'(cnt);
    START       = 1'b1;
    step();
    START       = 1'b0;
    FRAME_LEN   = 16'hABCD;
    FRAME_COUNT = 32'd7;
    while (!done_seen && iter < 4000) begin
      iter++;
      if (DONE) begin
        done_seen = 1;
        done_iter = iter;
      end else begin
        START = poke && (iter == 3);
        chk("src_rdy_in_send", TX_SRC_RDY, 1);
        if (stalled) begin
          chk("hold_data", TX_DATA, h_data);
          chk("hold_sof", TX_SOF, h_sof);
          chk("hold_eof", TX_EOF, h_eof);
          chk("hold_sof_pos", TX_SOF_POS, h_sp);
          chk("hold_eof_pos", TX_EOF_POS, h_ep);
        end
        rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        TX_DST_RDY = rdy;
        if (TX_SRC_RDY && rdy) begin
          chk("sof", TX_SOF, (w == 0) ? 4'b0001 : 4'b0000);
          chk("sof_pos", TX_SOF_POS, 12'h000);
          chk("eof", TX_EOF, (w == wpf - 1) ? eof_mask : 4'b0000);
          chk("eof_pos", TX_EOF_POS, (w == wpf - 1) ? eof_pos : 24'h0);
          check_data("data", f, w, len);
          if (len == 512 && f == 1 && w == 0) begin
            chk("f1_item0", TX_DATA[7:0], 8'd1);
            chk("f1_item255_wrap", TX_DATA[2047:2040], 8'd0);
          end
          if (len == 60) begin
            chk("item59", TX_DATA[479:472], 8'd59);
            chk("item60_zero", TX_DATA[487:480], 8'd0);
          end
          sig = {sig[30:0], sig[31]} ^ fold(TX_DATA) ^ {4'h0, TX_SOF, TX_EOF, TX_EOF_POS};
          nx++;
          last_x = iter;
          stalled = 0;
          w++;
          if (w == wpf) begin
            w = 0;
            f++;
          end
        end else if (TX_SRC_RDY) begin
          h_data = TX_DATA; h_sof = TX_SOF; h_eof = TX_EOF; h_sp = TX_SOF_POS; h_ep = TX_EOF_POS;
          stalled = 1;
        end
        step();
      end
    end
    START = 1'b0;
    TX_DST_RDY = 1'b1;
    chk("done_seen", done_seen, 1);
    chk("done_latency", done_iter, last_x + 1);
    chk("xfers", nx, exp_xfers);
    chk("frames", f, cnt);
    chk("busy_in_finish", BUSY, 1);
    chk("src_rdy_in_finish", TX_SRC_RDY, 0);
    step();
    chk("done_one_cycle", DONE, 0);
    chk("busy_back_idle", BUSY, 0);
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; TX_DST_RDY = 1'b1;
    FRAME_LEN = '0; FRAME_COUNT = '0;
    step();
    step();
    chk("rst_src_rdy", TX_SRC_RDY, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_sof", TX_SOF, 0);
    chk("rst_eof", TX_EOF, 0);
    chk("rst_sof_pos", TX_SOF_POS, 0);
    chk("rst_eof_pos", TX_EOF_POS, 0);
    RESET = 1'b0;
    step();

    // Single-word frame: SOF and EOF share the word
    run_stream(60, 1, 1'b0, 1'b0, 4'b0001, 24'd59, 1, sig_a);
    // Two 512-item frames: EOF in region 3 at item 63 on words 2 and 4
    run_stream(512, 2, 1'b0, 1'b0, 4'b1000, 24'hFC0000, 4, sig_a);
    // 65 items: EOF lands on item 0 of region 1
    run_stream(65, 3, 1'b0, 1'b0, 4'b0010, 24'h000000, 3, sig_a);
    // Same stream without and with backpressure; START poked mid-run
    run_stream(300, 20, 1'b0, 1'b0, 4'b0001, 24'd43, 40, sig_a);
    run_stream(300, 20, 1'b1, 1'b1, 4'b0001, 24'd43, 40, sig_b);
    chk("stall_stream_equal", sig_b, sig_a);

    // Reset on the second word of a 512-item frame
    FRAME_LEN = 16'd512; FRAME_COUNT = 32'd1; TX_DST_RDY = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    chk("mid_w0_src_rdy", TX_SRC_RDY, 1);
    chk("mid_w0_sof", TX_SOF, 4'b0001);
    step();
    chk("mid_w1_src_rdy", TX_SRC_RDY, 1);
    chk("mid_w1_sof", TX_SOF, 4'b0000);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("abort_src_rdy", TX_SRC_RDY, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_eof", TX_EOF, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", DONE, 0);
    end
    run_stream(60, 1, 1'b0, 1'b0, 4'b0001, 24'd59, 1, sig_a);

    // RESET wins over a simultaneous START
    FRAME_LEN = 16'd60; FRAME_COUNT = 32'd1; RESET = 1'b1; START = 1'b1;
    step();
    RESET = 1'b0; START = 1'b0;
    chk("rst_prio_busy", BUSY, 0);
    chk("rst_prio_src_rdy", TX_SRC_RDY, 0);
    step();
    chk("rst_prio_idle", BUSY, 0);

    // FRAME_COUNT = 0: one FINISH cycle, START during it is ignored
    FRAME_LEN = 16'd60; FRAME_COUNT = 32'd0; START = 1'b1;
    step();
    FRAME_COUNT = 32'd1;
    chk("cnt0_src_rdy", TX_SRC_RDY, 0);
    chk("cnt0_busy", BUSY, 1);
    chk("cnt0_done", DONE, 1);
    step();
    START = 1'b0;
    chk("cnt0_idle_busy", BUSY, 0);
    chk("cnt0_idle_done", DONE, 0);
    chk("cnt0_idle_src_rdy", TX_SRC_RDY, 0);
    step();
    chk("start_in_finish_ignored", BUSY, 0);

    // FRAME_LEN = 0 behaves the same way
    FRAME_LEN = 16'd0; FRAME_COUNT = 32'd5; START = 1'b1;
    step();
    START = 1'b0;
    chk("len0_src_rdy", TX_SRC_RDY, 0);
    chk("len0_done", DONE, 1);
    step();
    chk("len0_idle", BUSY, 0);
    chk("len0_src_rdy_idle", TX_SRC_RDY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
